exc_sched: RTL and testbench

//  Pipeline exception/interrupt sequencer for the OpenMIPS core; it drives the CP0 register file and the pipeline.

---
 rtl/exc_sched.sv | 102 ++++++++++
 tb/tb_exc_sched.sv | 261 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/exc_sched.sv
// Exception/interrupt sequencer: interrupt sync, stall arbitration,
// and the flush/redirect sequence for exceptions committed in MEM.
module exc_sched #(
    parameter logic [31:0] EXC_VECTOR   = 32'h00000020,
    parameter int          FLUSH_CYCLES = 2,
    parameter int          CNT_W        = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [5:0]       int_raw_i,
    input  logic             stallreq_id_i,
    input  logic             stallreq_ex_i,
    input  logic             mem_inst_valid_i,
    input  logic [31:0]      excepttype_i,
    input  logic [31:0]      cp0_status_i,
    input  logic [31:0]      cp0_cause_i,
    input  logic [31:0]      cp0_epc_i,
    output logic [5:0]       int_o,
    output logic             int_pending_o,
    output logic [5:0]       stall_o,
    output logic             flush_o,
    output logic [31:0]      new_pc_o,
    output logic             new_pc_valid_o,
    output logic             busy_o,
    output logic [CNT_W-1:0] exc_cnt_o
);

    typedef enum logic {IDLE, FLUSH} state_t;

    localparam logic [3:0] FL_INIT = 4'(FLUSH_CYCLES - 1);
    localparam logic [31:0] ERET = 32'h0000000e;

    state_t     state, state_n;
    logic [3:0] cnt, cnt_n;
    logic [5:0] int_s1;
    logic       accept;
    logic       pend_n;

    assign pend_n = (|(cp0_cause_i[15:8] & cp0_status_i[15:8]))
                  & cp0_status_i[0] & ~cp0_status_i[1];

    always_comb begin
        state_n = state;
        cnt_n   = cnt;
        accept  = 1'b0;
        stall_o = 6'b000000;
        unique case (state)
            IDLE: begin
                accept = mem_inst_valid_i && (excepttype_i != 32'h0);
                if (accept) begin
                    state_n = FLUSH;
                    cnt_n   = FL_INIT;
                end else if (stallreq_ex_i) begin
                    stall_o = 6'b001111;
                end else if (stallreq_id_i) begin
                    stall_o = 6'b000111;
                end
            end
            FLUSH: begin
                if (cnt == 4'd0) begin
                    state_n = IDLE;
                end else begin
                    cnt_n = cnt - 4'd1;
                end
            end
            default: ;
        endcase
        // stall is combinational, so hold it low while reset is asserted
        if (!rst) begin
            stall_o = 6'b000000;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state          <= IDLE;
            cnt            <= 4'd0;
            int_s1         <= 6'b0;
            int_o          <= 6'b0;
            int_pending_o  <= 1'b0;
            flush_o        <= 1'b0;
            busy_o         <= 1'b0;
            new_pc_valid_o <= 1'b0;
            new_pc_o       <= 32'h0;
            exc_cnt_o      <= '0;
        end else begin
            state          <= state_n;
            cnt            <= cnt_n;
            int_s1         <= int_raw_i;
            int_o          <= int_s1;
            int_pending_o  <= pend_n;
            flush_o        <= (state_n == FLUSH);
            busy_o         <= (state_n == FLUSH);
            new_pc_valid_o <= accept;
            if (accept) begin
                new_pc_o  <= (excepttype_i == ERET) ? cp0_epc_i : EXC_VECTOR;
                exc_cnt_o <= exc_cnt_o + CNT_W'(1);
            end
        end
    end

endmodule

// File: tb/tb_exc_sched.sv
// Bench for exc_sched: cycle-level model plus directed literal checks.
module tb_exc_sched;

    localparam int FC = 2;
    localparam int CW = 4;

    logic          clk = 1'b0;
    logic          rst;
    logic [5:0]    int_raw_i;
    logic          stallreq_id_i;
    logic          stallreq_ex_i;
    logic          mem_inst_valid_i;
    logic [31:0]   excepttype_i;
    logic [31:0]   cp0_status_i;
    logic [31:0]   cp0_cause_i;
    logic [31:0]   cp0_epc_i;
    logic [5:0]    int_o;
    logic          int_pending_o;
    logic [5:0]    stall_o;
    logic          flush_o;
    logic [31:0]   new_pc_o;
    logic          new_pc_valid_o;
    logic          busy_o;
    logic [CW-1:0] exc_cnt_o;

    int n_checks = 0;
    int n_err    = 0;

    exc_sched #(
        .EXC_VECTOR  (32'h00000020),
        .FLUSH_CYCLES(FC),
        .CNT_W       (CW)
    ) dut (
        .clk             (clk),
        .rst             (rst),
        .int_raw_i       (int_raw_i),
        .stallreq_id_i   (stallreq_id_i),
        .stallreq_ex_i   (stallreq_ex_i),
        .mem_inst_valid_i(mem_inst_valid_i),
        .excepttype_i    (excepttype_i),
        .cp0_status_i    (cp0_status_i),
        .cp0_cause_i     (cp0_cause_i),
        .cp0_epc_i       (cp0_epc_i),
        .int_o           (int_o),
        .int_pending_o   (int_pending_o),
        .stall_o         (stall_o),
        .flush_o         (flush_o),
        .new_pc_o        (new_pc_o),
        .new_pc_valid_o  (new_pc_valid_o),
        .busy_o          (busy_o),
        .exc_cnt_o       (exc_cnt_o)
    );

    always #5 clk = ~clk;

    task automatic check(string name, logic [31:0] act, logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // model: flush cycles remaining, redirect pulse, target, count
    int          m_left;
    logic        m_first;
    logic [31:0] m_pc;
    int          m_cnt;
    logic [5:0]  m_hist [2];
    logic        m_pend;

    always @(posedge clk or negedge rst) begin
        if (!rst) begin
            m_left    = 0;
            m_first   = 1'b0;
            m_pc      = 32'h0;
            m_cnt     = 0;
            m_hist[0] = 6'b0;
            m_hist[1] = 6'b0;
            m_pend    = 1'b0;
        end else begin
            m_hist[1] = m_hist[0];
            m_hist[0] = int_raw_i;
            m_pend = (|(cp0_cause_i[15:8] & cp0_status_i[15:8]))
                   && cp0_status_i[0] && !cp0_status_i[1];
            m_first = 1'b0;
            if (m_left > 0) begin
                m_left = m_left - 1;
            end else if (mem_inst_valid_i && excepttype_i != 0) begin
                m_left  = FC;
                m_first = 1'b1;
                m_pc    = (excepttype_i == 32'he) ? cp0_epc_i : 32'h20;
                m_cnt   = (m_cnt + 1) % (1 << CW);
            end
        end
    end

    always @(negedge clk) begin
        logic [5:0] es;
        if (rst) begin
            es = 6'b0;
            if (m_left == 0 && !(mem_inst_valid_i && excepttype_i != 0)) begin
                if (stallreq_ex_i) es = 6'b001111;
                else if (stallreq_id_i) es = 6'b000111;
            end
            check("m_stall", 32'(stall_o), 32'(es));
            check("m_flush", 32'(flush_o), 32'(m_left > 0));
            check("m_busy", 32'(busy_o), 32'(m_left > 0));
            check("m_npv", 32'(new_pc_valid_o), 32'(m_first));
            check("m_pc", new_pc_o, m_pc);
            check("m_cnt", 32'(exc_cnt_o), 32'(m_cnt));
            check("m_int", 32'(int_o), 32'(m_hist[1]));
            check("m_pend", 32'(int_pending_o), 32'(m_pend));
        end
    end

    initial begin
        rst = 1'b0;
        int_raw_i = 6'b0;
        stallreq_id_i = 1'b0;
        stallreq_ex_i = 1'b0;
        mem_inst_valid_i = 1'b0;
        excepttype_i = 32'h0;
        cp0_status_i = 32'h0;
        cp0_cause_i = 32'h0;
        cp0_epc_i = 32'h0;
        stallreq_ex_i = 1'b1;
        repeat (2) step();
        check("rst_stall", 32'(stall_o), 32'h0);
        check("rst_flush", 32'(flush_o), 32'h0);
        check("rst_cnt", 32'(exc_cnt_o), 32'h0);
        stallreq_ex_i = 1'b0;
        rst = 1'b1;
        step();

        // T1: async reset in the middle of a flush
        excepttype_i = 32'h8;
        mem_inst_valid_i = 1'b1;
        step();
        excepttype_i = 32'h0;
        mem_inst_valid_i = 1'b0;
        #1;
        check("t1_flush_pre", 32'(flush_o), 32'h1);
        #1 rst = 1'b0;
        #1;
        check("t1_flush", 32'(flush_o), 32'h0);
        check("t1_busy", 32'(busy_o), 32'h0);
        check("t1_npv", 32'(new_pc_valid_o), 32'h0);
        check("t1_pc", new_pc_o, 32'h0);
        check("t1_cnt", 32'(exc_cnt_o), 32'h0);
        step();
        rst = 1'b1;
        step();
        check("t1_after_flush", 32'(flush_o), 32'h0);
        check("t1_after_cnt", 32'(exc_cnt_o), 32'h0);

        // T2: stall arbitration
        stallreq_ex_i = 1'b1;
        stallreq_id_i = 1'b1;
        #1 check("t2_ex_id", 32'(stall_o), 32'h0f);
        step();
        stallreq_ex_i = 1'b0;
        #1 check("t2_id", 32'(stall_o), 32'h07);
        step();
        stallreq_id_i = 1'b0;
        #1 check("t2_none", 32'(stall_o), 32'h00);
        step();

        // T3: syscall overriding an EX stall
        stallreq_ex_i = 1'b1;
        excepttype_i = 32'h8;
        mem_inst_valid_i = 1'b1;
        #1 check("t3_stall_n", 32'(stall_o), 32'h0);
        step();
        excepttype_i = 32'h0;
        mem_inst_valid_i = 1'b0;
        #1;
        check("t3_flush1", 32'(flush_o), 32'h1);
        check("t3_npv1", 32'(new_pc_valid_o), 32'h1);
        check("t3_pc", new_pc_o, 32'h20);
        check("t3_cnt", 32'(exc_cnt_o), 32'h1);
        check("t3_stall1", 32'(stall_o), 32'h0);
        step();
        check("t3_flush2", 32'(flush_o), 32'h1);
        check("t3_npv2", 32'(new_pc_valid_o), 32'h0);
        step();
        check("t3_busy3", 32'(busy_o), 32'h0);
        check("t3_stall3", 32'(stall_o), 32'h0f);
        stallreq_ex_i = 1'b0;
        step();

        // T4: eret then a squashed exception during flush
        cp0_epc_i = 32'hBFC00100;
        excepttype_i = 32'he;
        mem_inst_valid_i = 1'b1;
        step();
        excepttype_i = 32'h0;
        mem_inst_valid_i = 1'b0;
        #1 check("t4_pc", new_pc_o, 32'hBFC00100);
        step();
        excepttype_i = 32'hc;
        mem_inst_valid_i = 1'b1;
        step();
        excepttype_i = 32'h0;
        mem_inst_valid_i = 1'b0;
        #1 check("t4_cnt", 32'(exc_cnt_o), 32'h2);
        step();
        check("t4_flush", 32'(flush_o), 32'h0);
        check("t4_pc_hold", new_pc_o, 32'hBFC00100);

        // T5: interrupt synchroniser and pending flag
        int_raw_i = 6'b000100;
        step();
        check("t5_int_1edge", 32'(int_o), 32'h0);
        step();
        check("t5_int_2edge", 32'(int_o), 32'h4);
        cp0_status_i = 32'h10000401;
        cp0_cause_i = 32'h00000400;
        step();
        check("t5_pend", 32'(int_pending_o), 32'h1);
        cp0_status_i = 32'h10000403;
        step();
        check("t5_exl", 32'(int_pending_o), 32'h0);
        int_raw_i = 6'b101001;
        repeat (3) step();
        check("t5_int_mix", 32'(int_o), 32'h29);

        // T6: gating on valid, then back-to-back accepts and wrap
        excepttype_i = 32'h1;
        mem_inst_valid_i = 1'b0;
        step();
        excepttype_i = 32'h0;
        #1;
        check("t6_gate_flush", 32'(flush_o), 32'h0);
        check("t6_gate_cnt", 32'(exc_cnt_o), 32'h2);
        rst = 1'b0;
        step();
        rst = 1'b1;
        step();
        excepttype_i = 32'h1;
        mem_inst_valid_i = 1'b1;
        for (int i = 0; i < 16; i++) begin
            repeat (3) step();
            if (i == 14) check("t6_cnt15", 32'(exc_cnt_o), 32'hf);
        end
        excepttype_i = 32'h0;
        mem_inst_valid_i = 1'b0;
        #1 check("t6_wrap", 32'(exc_cnt_o), 32'h0);
        repeat (4) step();

        $display("Simulation finished: %0d checks, %0d errors",
                 n_checks, n_err);
        $finish;
    end

endmodule
